ps2_command_packer: RTL and testbench
=====================================

# ps2_command_packer

Assembles PS/2 keyboard scan-code bytes into 32-bit ASCII command words for the processor. Sits directly between the PS/2 interface (byte strobe plus scan code) and the processor's command input. It replaces ad hoc shifting of raw key data with four functions: break/extended-code filtering, line editing (backspace, enter), an explicit valid/ack handshake, and a per-keystroke echo strobe for the LCD.

## Interface
- MAX_CHARS, 4, characters per command word; fixed at 4 because 4 × 8 bits = 32.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- key_pressed  in  1  byte-received indication from the PS/2 interface; may stay high more than one cycle.
- key_data  in  8  scan-code byte, valid whenever key_pressed is high.
- command_ack  in  1  processor has consumed command.
- command  out  32  committed command; first-typed character in the most significant occupied byte.
- command_valid  out  1  command holds an unconsumed word.
- char_count  out  3  characters currently in the edit buffer (0..4).
- overflow  out  1  sticky; a character was dropped because the buffer was full.
- echo_valid  out  1  one-cycle pulse per accepted keystroke.
- echo_char  out  8  ASCII echo code, qualified by echo_valid.

## Operation
- Byte event: a 0→1 edge of key_pressed, detected against a registered copy of key_pressed. Exactly one event per edge.
- Decoder FSM states:
  - MAKE (reset state):
    - F0 → BREAK.
    - E0 → EXT.
    - Any other byte → process as make code, stay in MAKE.
  - BREAK: next byte discarded → MAKE.
  - EXT:
    - F0 → EXT_BREAK.
    - Any other byte discarded → MAKE.
  - EXT_BREAK: next byte discarded → MAKE.
- Make-code processing, in priority order:
  - 5A (Enter): commit. Echo 0D.
  - 66 (Backspace):
    - char_count > 0: buffer shifts right 8, low byte lost, upper byte filled with 00, char_count − 1, echo 08.
    - char_count = 0: no effect, no echo.
  - 29 (Space): character 20.
  - Letters A–Z and digits 0–9: the standard set-2 table (1C→41 'A' … 1A→5A 'Z', 45→30 '0' … 46→39 '9').
  - Any other code: ignored, no echo.
- Character accept:
  - char_count < 4: buffer <= {buffer[23:0], ascii}, char_count + 1, echo the ASCII code.
  - char_count = 4: character dropped, overflow <= 1, no echo.
- Commit, when Enter arrives:
  - Allowed only if char_count > 0 and the output slot is free. The slot is free when command_valid = 0, or when command_ack = 1 in the same cycle.
  - On commit: command <= buffer, command_valid <= 1, buffer <= 0, char_count <= 0, overflow <= 0.
  - If commit is not allowed, Enter is ignored: no echo, and the buffer and overflow are unchanged.
- Handshake:
  - command_valid = 1 and command_ack = 1 with no commit in that cycle → command_valid <= 0 next cycle; command keeps its value.
  - command_ack while command_valid = 0 is ignored.
- Unused upper bytes of a short command are 00. For example, "FD" gives 0000_4644.

## Timing
- Reset values:
  - command = 0, command_valid = 0, char_count = 0, overflow = 0.
  - echo_valid = 0, echo_char = 0.
  - FSM in MAKE, edit buffer = 0.
  - Registered key_pressed copy = 0, so a key_pressed already high when reset releases produces an event on the first cycle after release.
- Latency:
  - Counted from the rising edge of clock that samples key_pressed 0→1.
  - Buffer, char_count, overflow, command and command_valid are updated at that same edge.
  - echo_valid is high for exactly the following cycle.
- Every output is registered; there are no combinational paths from input to output.
- Reset takes precedence over every other input. Reset in the middle of a sequence (after F0/E0, or with a partial buffer) discards all state; the next byte is decoded from MAKE.
- Simultaneous key event and command_ack: both take effect in the same cycle. An Enter in that cycle commits the new word, and command_valid stays 1.
- Keys typed while command_valid = 1 keep filling the edit buffer; only Enter is blocked.

## Test plan
- Reset, then type F, D, Enter (2B, F0 2B, 23, F0 23, 5A, F0 5A):
  - command = 0000_4644 and command_valid = 1.
  - echo_char sequence 46, 44, 0D.
  - Break bytes produce no echo.
- Type A B C D E, then Enter:
  - E is dropped and overflow = 1 before Enter.
  - command = 4142_4344.
  - overflow clears on commit.
- Type A B, Backspace, C, Enter:
  - char_count goes 1, 2, 1, 2.
  - echo_char sequence 41, 42, 08, 43, 0D.
  - command = 0000_4143.
- With command_valid = 1 and no ack: type X, Enter. The Enter is ignored and char_count = 1. Then:
  - Pulse command_ack with no key event → command_valid = 0 next cycle.
  - Enter → command = 0000_0058.
  - Repeat, but with Enter and command_ack in the same cycle → command_valid stays 1 and command = 0000_0058.
- Extended and ignored keys:
  - E0 75, E0 F0 75 (arrow keys) produce no buffer change and no echo.
  - key_pressed held high for 5 cycles with data 1C produces exactly one 'A'.
- Reset asserted for one cycle after an F0, with char_count = 3:
  - Afterwards, 1C is accepted as 'A' with char_count = 1.
  - All outputs read their reset values during the reset cycle.

Source files
------------

// File: rtl/ps2_command_packer.sv
// ps2_command_packer
//   Turns PS/2 set-2 scan-code bytes into 32-bit ASCII command words.
//   It drops break and extended sequences and handles Backspace and Enter.
//   A committed word is held under a valid/ack handshake.
//   Each accepted keystroke produces a one-cycle echo strobe.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   key_pressed    in   byte strobe from the PS/2 interface (edge-detected)
//   key_data[7:0]  in   scan-code byte, valid while key_pressed is high
//   command_ack    in   processor has consumed the command word
//   command[31:0]  out  committed word, first character in the highest used byte
//   command_valid  out  command holds an unconsumed word
//   char_count[2:0]out  characters in the edit buffer (0..4)
//   overflow       out  sticky: a character was dropped on a full buffer
//   echo_valid     out  one-cycle pulse per accepted keystroke
//   echo_char[7:0] out  ASCII echo code, qualified by echo_valid
module ps2_command_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_pressed,
  input  logic [7:0]  key_data,
  input  logic        command_ack,
  output logic [31:0] command,
  output logic        command_valid,
  output logic [2:0]  char_count,
  output logic        overflow,
  output logic        echo_valid,
  output logic [7:0]  echo_char
);

  localparam int MAX_CHARS = 4;

  typedef enum logic [1:0] {
    MAKE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t      state_r, state_n;
  logic        key_prev_r;
  logic [31:0] buffer_r, buffer_n;
  logic [2:0]  count_n;
  logic        overflow_n;
  logic [31:0] command_n;
  logic        valid_n;
  logic        echo_valid_n;
  logic [7:0]  echo_char_n;
  logic        event_s;
  logic        slot_free_s;
  logic [8:0]  ascii_s;

  // Set-2 make code to ASCII; bit 8 flags a printable character.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h29: scan_to_ascii = {1'b1, 8'h20};
      8'h1C: scan_to_ascii = {1'b1, 8'h41};
      8'h32: scan_to_ascii = {1'b1, 8'h42};
      8'h21: scan_to_ascii = {1'b1, 8'h43};
      8'h23: scan_to_ascii = {1'b1, 8'h44};
      8'h24: scan_to_ascii = {1'b1, 8'h45};
      8'h2B: scan_to_ascii = {1'b1, 8'h46};
      8'h34: scan_to_ascii = {1'b1, 8'h47};
      8'h33: scan_to_ascii = {1'b1, 8'h48};
      8'h43: scan_to_ascii = {1'b1, 8'h49};
      8'h3B: scan_to_ascii = {1'b1, 8'h4A};
      8'h42: scan_to_ascii = {1'b1, 8'h4B};
      8'h4B: scan_to_ascii = {1'b1, 8'h4C};
      8'h3A: scan_to_ascii = {1'b1, 8'h4D};
      8'h31: scan_to_ascii = {1'b1, 8'h4E};
      8'h44: scan_to_ascii = {1'b1, 8'h4F};
      8'h4D: scan_to_ascii = {1'b1, 8'h50};
      8'h15: scan_to_ascii = {1'b1, 8'h51};
      8'h2D: scan_to_ascii = {1'b1, 8'h52};
      8'h1B: scan_to_ascii = {1'b1, 8'h53};
      8'h2C: scan_to_ascii = {1'b1, 8'h54};
      8'h3C: scan_to_ascii = {1'b1, 8'h55};
      8'h2A: scan_to_ascii = {1'b1, 8'h56};
      8'h1D: scan_to_ascii = {1'b1, 8'h57};
      8'h22: scan_to_ascii = {1'b1, 8'h58};
      8'h35: scan_to_ascii = {1'b1, 8'h59};
      8'h1A: scan_to_ascii = {1'b1, 8'h5A};
      8'h45: scan_to_ascii = {1'b1, 8'h30};
      8'h16: scan_to_ascii = {1'b1, 8'h31};
      8'h1E: scan_to_ascii = {1'b1, 8'h32};
      8'h26: scan_to_ascii = {1'b1, 8'h33};
      8'h25: scan_to_ascii = {1'b1, 8'h34};
      8'h2E: scan_to_ascii = {1'b1, 8'h35};
      8'h36: scan_to_ascii = {1'b1, 8'h36};
      8'h3D: scan_to_ascii = {1'b1, 8'h37};
      8'h3E: scan_to_ascii = {1'b1, 8'h38};
      8'h46: scan_to_ascii = {1'b1, 8'h39};
      default: scan_to_ascii = 9'h000;
    endcase
  endfunction

  assign event_s     = key_pressed & ~key_prev_r;
  // Ack in the same cycle frees the slot for a new commit.
  assign slot_free_s = ~command_valid | command_ack;
  assign ascii_s     = scan_to_ascii(key_data);

  // Decoder FSM next state, line editing, commit and handshake.
  always_comb begin
    state_n      = state_r;
    buffer_n     = buffer_r;
    count_n      = char_count;
    overflow_n   = overflow;
    command_n    = command;
    valid_n      = command_valid;
    echo_valid_n = 1'b0;
    echo_char_n  = echo_char;

    if (command_valid && command_ack) begin
      valid_n = 1'b0;
    end else begin
      valid_n = command_valid;
    end

    if (event_s) begin
      case (state_r)
        MAKE: begin
          if (key_data == 8'hF0) begin
            state_n = BREAK;
          end else if (key_data == 8'hE0) begin
            state_n = EXT;
          end else if (key_data == 8'h5A) begin
            if ((char_count != 3'd0) && slot_free_s) begin
              command_n    = buffer_r;
              valid_n      = 1'b1;
              buffer_n     = 32'h0000_0000;
              count_n      = 3'd0;
              overflow_n   = 1'b0;
              echo_valid_n = 1'b1;
              echo_char_n  = 8'h0D;
            end else begin
              command_n = command;
            end
          end else if (key_data == 8'h66) begin
            if (char_count != 3'd0) begin
              buffer_n     = {8'h00, buffer_r[31:8]};
              count_n      = char_count - 3'd1;
              echo_valid_n = 1'b1;
              echo_char_n  = 8'h08;
            end else begin
              buffer_n = buffer_r;
            end
          end else if (ascii_s[8]) begin
            if (char_count < 3'(MAX_CHARS)) begin
              buffer_n     = {buffer_r[23:0], ascii_s[7:0]};
              count_n      = char_count + 3'd1;
              echo_valid_n = 1'b1;
              echo_char_n  = ascii_s[7:0];
            end else begin
              overflow_n = 1'b1;
            end
          end else begin
            state_n = MAKE;
          end
        end
        BREAK:     state_n = MAKE;
        EXT:       state_n = (key_data == 8'hF0) ? EXT_BREAK : MAKE;
        EXT_BREAK: state_n = MAKE;
        default:   state_n = MAKE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= MAKE;
      key_prev_r    <= 1'b0;
      buffer_r      <= 32'h0000_0000;
      char_count    <= 3'd0;
      overflow      <= 1'b0;
      command       <= 32'h0000_0000;
      command_valid <= 1'b0;
      echo_valid    <= 1'b0;
      echo_char     <= 8'h00;
    end else begin
      state_r       <= state_n;
      key_prev_r    <= key_pressed;
      buffer_r      <= buffer_n;
      char_count    <= count_n;
      overflow      <= overflow_n;
      command       <= command_n;
      command_valid <= valid_n;
      echo_valid    <= echo_valid_n;
      echo_char     <= echo_char_n;
    end
  end

endmodule

// File: tb/tb_ps2_command_packer.sv
// Directed bench for ps2_command_packer: inputs change on the falling edge,
// outputs are sampled on the falling edge after the active edge.
module tb_ps2_command_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_pressed = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        command_ack = 1'b0;
  logic [31:0] command;
  logic        command_valid;
  logic [2:0]  char_count;
  logic        overflow;
  logic        echo_valid;
  logic [7:0]  echo_char;

  int errors = 0;
  int checks = 0;
  logic       ev;
  logic [7:0] ec;
  int pulses;

  ps2_command_packer dut (
    .clock(clock), .reset(reset), .key_pressed(key_pressed),
    .key_data(key_data), .command_ack(command_ack), .command(command),
    .command_valid(command_valid), .char_count(char_count),
    .overflow(overflow), .echo_valid(echo_valid), .echo_char(echo_char)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte event; echo outputs captured in the cycle after the event edge.
  task automatic key(input logic [7:0] b, input logic with_ack);
    @(negedge clock);
    key_pressed = 1'b1; key_data = b; command_ack = with_ack;
    @(negedge clock);
    key_pressed = 1'b0; command_ack = 1'b0;
    ev = echo_valid; ec = echo_char;
    @(negedge clock);
  endtask

  // Make code followed by its break sequence; echo from the make byte kept.
  task automatic tap(input logic [7:0] code);
    logic       v;
    logic [7:0] c;
    key(code, 1'b0);
    v = ev; c = ec;
    key(8'hF0, 1'b0);
    chk("break_f0_no_echo", {31'd0, ev}, 32'd0);
    key(code, 1'b0);
    chk("break_code_no_echo", {31'd0, ev}, 32'd0);
    ev = v; ec = c;
  endtask

  task automatic ack_pulse();
    @(negedge clock); command_ack = 1'b1;
    @(negedge clock); command_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_command", command, 32'h0);
    chk("rst_valid", {31'd0, command_valid}, 32'd0);
    chk("rst_count", {29'd0, char_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_echo_valid", {31'd0, echo_valid}, 32'd0);
    chk("rst_echo_char", {24'd0, echo_char}, 32'd0);
    reset = 1'b0;

    // F D Enter
    tap(8'h2B); chk("fd_echo_f", {23'd0, ev, ec}, {23'd0, 1'b1, 8'h46});
    tap(8'h23); chk("fd_echo_d", {23'd0, ev, ec}, {23'd0, 1'b1, 8'h44});
    tap(8'h5A); chk("fd_echo_cr", {23'd0, ev, ec}, {23'd0, 1'b1, 8'h0D});
    chk("fd_command", command, 32'h0000_4644);
    chk("fd_valid", {31'd0, command_valid}, 32'd1);
    ack_pulse();
    chk("fd_ack_clears", {31'd0, command_valid}, 32'd0);
    chk("fd_command_kept", command, 32'h0000_4644);

    // A B C D E (overflow), Enter
    tap(8'h1C); tap(8'h32); tap(8'h21); tap(8'h23);
    tap(8'h24);
    chk("ovf_e_no_echo", {31'd0, ev}, 32'd0);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {29'd0, char_count}, 32'd4);
    tap(8'h5A);
    chk("ovf_command", command, 32'h4142_4344);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    chk("ovf_count_zero", {29'd0, char_count}, 32'd0);
    ack_pulse();

    // Backspace on empty buffer: no echo
    tap(8'h66);
    chk("bs_empty_no_echo", {31'd0, ev}, 32'd0);

    // A B Backspace C Enter
    tap(8'h1C); chk("bs_a", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd1, 1'b1, 8'h41});
    tap(8'h32); chk("bs_b", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd2, 1'b1, 8'h42});
    tap(8'h66); chk("bs_bs", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd1, 1'b1, 8'h08});
    tap(8'h21); chk("bs_c", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd2, 1'b1, 8'h43});
    tap(8'h5A); chk("bs_cr", {23'd0, ev, ec}, {23'd0, 1'b1, 8'h0D});
    chk("bs_command", command, 32'h0000_4143);

    // Valid still set, no ack: X then blocked Enter
    tap(8'h22); chk("blk_x", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd1, 1'b1, 8'h58});
    tap(8'h5A);
    chk("blk_enter_no_echo", {31'd0, ev}, 32'd0);
    chk("blk_count", {29'd0, char_count}, 32'd1);
    chk("blk_command", command, 32'h0000_4143);
    ack_pulse();
    chk("blk_ack_clears", {31'd0, command_valid}, 32'd0);
    tap(8'h5A);
    chk("blk_command_x", command, 32'h0000_0058);
    chk("blk_valid", {31'd0, command_valid}, 32'd1);

    // Enter with ack in the same cycle
    tap(8'h22);
    key(8'h5A, 1'b1);
    chk("same_echo", {23'd0, ev, ec}, {23'd0, 1'b1, 8'h0D});
    chk("same_valid", {31'd0, command_valid}, 32'd1);
    chk("same_command", command, 32'h0000_0058);
    chk("same_count", {29'd0, char_count}, 32'd0);
    key(8'hF0, 1'b0); key(8'h5A, 1'b0);
    ack_pulse();
    chk("same_ack_clears", {31'd0, command_valid}, 32'd0);

    // Extended keys: no echo, no buffer change
    key(8'hE0, 1'b0); chk("ext_e0", {31'd0, ev}, 32'd0);
    key(8'h75, 1'b0); chk("ext_75", {31'd0, ev}, 32'd0);
    key(8'hE0, 1'b0); key(8'hF0, 1'b0);
    key(8'h75, 1'b0); chk("ext_brk_75", {31'd0, ev}, 32'd0);
    chk("ext_count", {29'd0, char_count}, 32'd0);
    // Ignored make code
    tap(8'h76); chk("ignored_no_echo", {31'd0, ev}, 32'd0);

    // Held key_pressed gives exactly one event
    pulses = 0;
    @(negedge clock); key_pressed = 1'b1; key_data = 8'h1C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (echo_valid) pulses++;
    end
    key_pressed = 1'b0;
    @(negedge clock);
    if (echo_valid) pulses++;
    chk("hold_one_pulse", pulses, 32'd1);
    chk("hold_count", {29'd0, char_count}, 32'd1);

    // Reset after F0 with a partial buffer
    tap(8'h32); tap(8'h21);
    chk("mid_count3", {29'd0, char_count}, 32'd3);
    key(8'hF0, 1'b0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_command", command, 32'h0);
    chk("mid_rst_count", {29'd0, char_count}, 32'd0);
    chk("mid_rst_misc", {29'd0, command_valid, overflow, echo_valid}, 32'd0);
    chk("mid_rst_echo_char", {24'd0, echo_char}, 32'd0);
    reset = 1'b0;
    key(8'h1C, 1'b0);
    chk("mid_a", {20'd0, 1'b0, char_count, ev, ec}, {20'd0, 1'b0, 3'd1, 1'b1, 8'h41});
    key(8'hF0, 1'b0); key(8'h1C, 1'b0);
    tap(8'h5A);
    chk("mid_command", command, 32'h0000_0041);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
